// File: rtl/cordic_sequencer.sv
// Control sequencer for an iterative CORDIC rotator: accepts an angle command, waits on the
// quarter identifier, loads the rotation core, steps it through its iterations and holds the result.
module cordic_sequencer #(
  parameter int PHI_WIDTH   = 22,
  parameter int ITERATIONS  = 16,
  parameter int ITER_W      = 5,
  parameter int QID_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [PHI_WIDTH-1:0] cmd_phi_i,
  input  logic                 abort_i,
  output logic                 qid_enable_o,
  output logic [PHI_WIDTH-1:0] qid_phi_o,
  input  logic [PHI_WIDTH-1:0] qid_phi_i,
  input  logic [1:0]           qid_quarter_i,
  input  logic                 qid_done_i,
  output logic                 core_load_o,
  output logic [PHI_WIDTH-1:0] core_phi_o,
  output logic                 core_step_o,
  output logic [ITER_W-1:0]    core_iter_o,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [1:0]           res_quarter_o,
  output logic                 res_err_o,
  output logic                 busy_o
);

  localparam int WAIT_W = (QID_TIMEOUT > 1) ? $clog2(QID_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(QID_TIMEOUT - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QUARTER = 3'd1,
    S_LOAD    = 3'd2,
    S_ITERATE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [ITER_W-1:0]      iter_q, iter_d;
  logic [1:0]             quarter_q, quarter_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   busy_q, busy_d;
  logic                   qid_enable_q, qid_enable_d;
  logic [PHI_WIDTH-1:0]   qid_phi_q, qid_phi_d;
  logic                   core_load_q, core_load_d;
  logic [PHI_WIDTH-1:0]   core_phi_q, core_phi_d;
  logic                   core_step_q, core_step_d;
  logic                   res_valid_q, res_valid_d;
  logic [1:0]             res_quarter_q, res_quarter_d;
  logic                   res_err_q, res_err_d;

  // Next-state and next-output computation; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    iter_d        = {ITER_W{1'b0}};
    quarter_d     = quarter_q;
    qid_phi_d     = qid_phi_q;
    core_phi_d    = core_phi_q;
    res_quarter_d = res_quarter_q;
    res_err_d     = res_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          state_d   = S_QUARTER;
          qid_phi_d = cmd_phi_i;
          wait_d    = {WAIT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_QUARTER: begin
        // Abort beats a result, and a result arriving on the last wait cycle beats the timeout.
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (qid_done_i) begin
          state_d    = S_LOAD;
          core_phi_d = qid_phi_i;
          quarter_d  = qid_quarter_i;
        end else if (wait_q == WAIT_LAST) begin
          state_d       = S_DONE;
          res_quarter_d = 2'b00;
          res_err_d     = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ITERATE;
          iter_d  = {ITER_W{1'b0}};
        end
      end
      S_ITERATE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (iter_q == ITER_LAST) begin
          state_d       = S_DONE;
          res_quarter_d = quarter_q;
          res_err_d     = 1'b0;
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      S_DONE: begin
        if (abort_i || res_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    qid_enable_d = (state_d == S_QUARTER);
    core_load_d  = (state_d == S_LOAD);
    core_step_d  = (state_d == S_ITERATE);
    res_valid_d  = (state_d == S_DONE);

    if (state_d != S_QUARTER) begin
      qid_phi_d = {PHI_WIDTH{1'b0}};
      wait_d    = {WAIT_W{1'b0}};
    end else begin
      qid_phi_d = qid_phi_d;
    end

    // Leaving the result state (handshake or abort) discards whatever was pending.
    if (state_d != S_DONE) begin
      res_quarter_d = 2'b00;
      res_err_d     = 1'b0;
    end else begin
      res_quarter_d = res_quarter_d;
    end

    if (state_d == S_IDLE) begin
      quarter_d = 2'b00;
    end else begin
      quarter_d = quarter_d;
    end
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= {WAIT_W{1'b0}};
      iter_q        <= {ITER_W{1'b0}};
      quarter_q     <= 2'b00;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      qid_enable_q  <= 1'b0;
      qid_phi_q     <= {PHI_WIDTH{1'b0}};
      core_load_q   <= 1'b0;
      core_phi_q    <= {PHI_WIDTH{1'b0}};
      core_step_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_quarter_q <= 2'b00;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      iter_q        <= iter_d;
      quarter_q     <= quarter_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      qid_enable_q  <= qid_enable_d;
      qid_phi_q     <= qid_phi_d;
      core_load_q   <= core_load_d;
      core_phi_q    <= core_phi_d;
      core_step_q   <= core_step_d;
      res_valid_q   <= res_valid_d;
      res_quarter_q <= res_quarter_d;
      res_err_q     <= res_err_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign qid_enable_o  = qid_enable_q;
  assign qid_phi_o     = qid_phi_q;
  assign core_load_o   = core_load_q;
  assign core_phi_o    = core_phi_q;
  assign core_step_o   = core_step_q;
  assign core_iter_o   = iter_q;
  assign res_valid_o   = res_valid_q;
  assign res_quarter_o = res_quarter_q;
  assign res_err_o     = res_err_q;

endmodule

// File: doc/cordic_sequencer.md
CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

Interface
REQ-001 The block SHALL have parameters PHI_WIDTH, default 22, angle word width (sign-magnitude: bit PHI_WIDTH-1 sign, bits [PHI_WIDTH-2:12] integer degrees, [11:0] fraction).
REQ-002 The block SHALL have parameter ITERATIONS, default 16, number of CORDIC micro-rotations per command.
REQ-003 The block SHALL have parameter ITER_W, default 5, iteration index width; ITER_W SHALL be at least clog2(ITERATIONS).
REQ-004 The block SHALL have parameter QID_TIMEOUT, default 8, maximum cycles to wait for quarter identification.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  single clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  sequencer can accept a command
- cmd_phi_i  in  PHI_WIDTH  requested angle
- abort_i  in  1  cancel the current operation
- qid_enable_o  out  1  enable to the quarter-identifier stage
- qid_phi_o  out  PHI_WIDTH  angle driven to the quarter identifier
- qid_phi_i  in  PHI_WIDTH  reduced angle returned by the quarter identifier
- qid_quarter_i  in  2  quarter returned by the quarter identifier
- qid_done_i  in  1  quarter identifier result valid
- core_load_o  out  1  one-cycle load strobe to the rotation core
- core_phi_o  out  PHI_WIDTH  reduced angle loaded into the core
- core_step_o  out  1  perform one micro-rotation this cycle
- core_iter_o  out  ITER_W  current iteration index
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result
- res_quarter_o  out  2  quarter for output correction
- res_err_o  out  1  quarter-identification timeout flag
- busy_o  out  1  state is not IDLE

Function
REQ-006 The block SHALL implement states IDLE, QUARTER, LOAD, ITERATE, DONE.
REQ-007 cmd_ready_o SHALL be 1 only in IDLE; a command SHALL be accepted when cmd_valid_i=1 and cmd_ready_o=1 on the same edge, capturing cmd_phi_i and entering QUARTER.
REQ-008 In QUARTER, qid_enable_o SHALL be 1 and qid_phi_o SHALL hold the captured angle; in every other state both SHALL be 0.
REQ-009 In QUARTER, when qid_done_i=1 the block SHALL capture qid_phi_i and qid_quarter_i and enter LOAD.
REQ-010 In QUARTER, a wait counter SHALL start at 0 on entry; if qid_done_i has not been 1 after QID_TIMEOUT cycles in QUARTER, the block SHALL enter DONE with res_err_o=1 and res_quarter_o=0.
REQ-011 LOAD SHALL last exactly one cycle, with core_load_o=1 and core_phi_o equal to the captured reduced angle; the next state SHALL be ITERATE.
REQ-012 ITERATE SHALL last exactly ITERATIONS cycles, with core_step_o=1 and core_iter_o counting 0..ITERATIONS-1; the block SHALL enter DONE after index ITERATIONS-1.
REQ-013 Outside ITERATE, core_step_o SHALL be 0 and core_iter_o SHALL be 0; core_phi_o SHALL hold its last loaded value.
REQ-014 In DONE, res_valid_o SHALL be 1, and res_quarter_o and res_err_o SHALL be held stable until the handshake completes (res_ready_i=1), after which the block SHALL return to IDLE; res_valid_o SHALL NOT depend combinationally on res_ready_i.
REQ-015 Latency: with qid_done_i first sampled high k cycles after acceptance, res_valid_o SHALL rise k+2+ITERATIONS cycles after acceptance.
REQ-016 If abort_i=1 in any non-IDLE state, the next state SHALL be IDLE with all strobes 0 and any pending result discarded.
REQ-017 abort_i SHALL take priority over a simultaneous qid_done_i, timeout or res_ready_i.
REQ-018 abort_i in IDLE SHALL have no effect and SHALL NOT block a simultaneous command acceptance.
REQ-019 A new command SHALL NOT be accepted in the same cycle a result is accepted; the earliest next acceptance is the following cycle.
REQ-020 busy_o SHALL equal (state != IDLE).

Reset
REQ-021 On a rising edge with rst=1, the block SHALL enter IDLE and SHALL clear all registered outputs: cmd_ready_o=1, busy_o=0, and all other outputs 0.
REQ-022 rst SHALL take priority over abort_i and all handshakes, including when asserted mid-operation.

Verification
REQ-023 Bench SHALL cover: 55 deg (22'h037000), model returns quarter 2'b00 with qid_done_i one cycle after qid_enable_o -> core_load_o pulse at cycle 3, core_step_o in cycles 4..19 with core_iter_o 0..15, res_valid_o at cycle 20 with res_quarter_o=00 and res_err_o=0.
REQ-024 Bench SHALL cover: 95 deg, model returns quarter 2'b01 and reduced angle 5 deg -> core_phi_o=5 deg at LOAD, res_quarter_o=01.
REQ-025 Bench SHALL cover: qid_done_i held 0 -> after exactly 8 QUARTER cycles, DONE with res_err_o=1 and no core_load_o pulse.
REQ-026 Bench SHALL cover: res_ready_i=0 for 5 cycles in DONE -> res_valid_o, res_quarter_o and res_err_o stable; cmd_valid_i held high is not accepted until the cycle after the result handshake.
REQ-027 Bench SHALL cover: abort_i at core_iter_o=7 -> IDLE next cycle, core_step_o=0, and no res_valid_o.
REQ-028 Bench SHALL cover: rst in ITERATE -> all outputs at reset values next cycle, after which a new command completes normally.
